// File: rtl/serial_defs_pkg.sv
// serial_defs: constants shared by the lane scheduler, paralelo_serial and serial_paralelo
package serial_defs;
    localparam logic [7:0] IDLE_SYM  = 8'hBC;
    localparam int         NUM_LANES = 4;
    typedef enum logic {ST_TRAIN = 1'b0, ST_ACTIVE = 1'b1} state_t;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: picks the first request at or after ptr, wrapping modulo N
module rr_priority_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any_grant
);
    logic [W-1:0] c;
    // Scan offsets from the far end so the nearest request to ptr is written last
    always_comb begin
        idx = '0;
        c = '0;
        any_grant = |req;
        for (int i = N - 1; i >= 0; i--) begin
            c = ptr + W'(i);
            if (req[c]) idx = c;
        end
        grant = any_grant ? (N'(1) << idx) : '0;
    end
endmodule

// File: rtl/serializer_lane_scheduler.sv
// serializer_lane_scheduler: trains the serial link with idle symbols, then round-robins
// source bytes onto the single paralelo_serial lane
module serializer_lane_scheduler
    import serial_defs::*;
#(
    parameter int         NUM_LANES     = serial_defs::NUM_LANES,
    parameter int         TRAIN_SYMBOLS = 4,
    parameter logic [7:0] IDLE_SYM      = serial_defs::IDLE_SYM,
    parameter int         W             = $clog2(NUM_LANES)
) (
    input  logic                   clk_4f,
    input  logic                   reset_L,
    input  logic [NUM_LANES-1:0]   valid_in,
    input  logic [8*NUM_LANES-1:0] data_in,
    input  logic                   pause,
    output logic [NUM_LANES-1:0]   ready_out,
    output logic [7:0]             data_out,
    output logic                   valid_out,
    output logic [W-1:0]           lane_id,
    output logic                   train_done
);
    localparam int CW = $clog2(TRAIN_SYMBOLS + 1);

    state_t         state, next_state;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   ptr, idx;
    logic [NUM_LANES-1:0] req, grant;
    logic           any_grant;

    assign req = (state == ST_ACTIVE && !pause) ? valid_in : '0;

    rr_priority_picker #(.N(NUM_LANES), .W(W)) u_pick (
        .req       (req),
        .ptr       (ptr),
        .grant     (grant),
        .idx       (idx),
        .any_grant (any_grant)
    );

    always_ff @(posedge clk_4f) begin
        if (!reset_L) state <= ST_TRAIN;
        else          state <= next_state;
    end

    always_comb begin
        next_state = (state == ST_TRAIN && cnt == CW'(TRAIN_SYMBOLS - 1)) ? ST_ACTIVE : state;
    end

    always_comb begin
        ready_out = grant;
    end

    // any_grant is only possible in ACTIVE, so TRAIN keeps the reset values on the outputs
    always_ff @(posedge clk_4f) begin
        if (!reset_L) begin
            cnt        <= '0;
            ptr        <= '0;
            data_out   <= IDLE_SYM;
            valid_out  <= 1'b0;
            lane_id    <= '0;
            train_done <= 1'b0;
        end else begin
            if (state == ST_TRAIN) cnt <= cnt + CW'(1);
            train_done <= next_state == ST_ACTIVE;
            data_out   <= any_grant ? data_in[8*idx +: 8] : IDLE_SYM;
            valid_out  <= any_grant;
            if (any_grant) begin
                lane_id <= idx;
                ptr     <= idx + W'(1);
            end
        end
    end
endmodule

// File: tb/tb_serializer_lane_scheduler.sv
// tb_serializer_lane_scheduler: directed checks of training, rotation, sparse requests,
// pause, mid-run reset and fairness
module tb_serializer_lane_scheduler;
    logic        clk_4f = 1'b0;
    logic        reset_L = 1'b0;
    logic        pause = 1'b0;
    logic [3:0]  valid_in = 4'hF;
    logic [31:0] data_in = 32'h037F_EEFF;
    logic [3:0]  ready_out;
    logic [7:0]  data_out;
    logic        valid_out;
    logic [1:0]  lane_id;
    logic        train_done;
    int          n_cmp = 0;
    int          n_err = 0;

    serializer_lane_scheduler #(.NUM_LANES(4), .TRAIN_SYMBOLS(4), .IDLE_SYM(8'hBC)) dut (
        .clk_4f     (clk_4f),
        .reset_L    (reset_L),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .pause      (pause),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .lane_id    (lane_id),
        .train_done (train_done)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_4f);
        #1;
    endtask

    task automatic out_chk(input string tag, input logic [7:0] d, input logic v, input logic [1:0] id);
        chk({tag, "_data"}, 32'(data_out), 32'(d));
        chk({tag, "_valid"}, 32'(valid_out), 32'(v));
        chk({tag, "_lane"}, 32'(lane_id), 32'(id));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rot_byte [5] = '{8'hFF, 8'hEE, 8'h7F, 8'h03, 8'hFF};
        logic [1:0] rot_lane [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [7:0] sp_byte  [4] = '{8'hEE, 8'h03, 8'hEE, 8'h03};
        logic [1:0] sp_lane  [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
        int wait_cnt = 0;
        int grants2 = 0;
        logic [3:0] r;
        logic g2;
        tick;
        tick;
        out_chk("rst", 8'hBC, 1'b0, 2'd0);
        chk("rst_done", 32'(train_done), 0);
        chk("rst_rdy", 32'(ready_out), 0);
        reset_L = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("train_rdy", 32'(ready_out), 0);
            tick;
            out_chk("train", 8'hBC, 1'b0, 2'd0);
            chk("train_done", 32'(train_done), (i == 4) ? 1 : 0);
        end
        for (int i = 0; i < 5; i++) begin
            chk("rot_rdy", 32'(ready_out), 32'(4'b0001 << rot_lane[i]));
            tick;
            out_chk("rot", rot_byte[i], 1'b1, rot_lane[i]);
        end
        valid_in = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #1 chk("sparse_rdy", 32'(ready_out), 32'(4'b0001 << sp_lane[i]));
            tick;
            out_chk("sparse", sp_byte[i], 1'b1, sp_lane[i]);
        end
        valid_in = 4'b0000;
        #1 chk("drop_rdy", 32'(ready_out), 0);
        tick;
        out_chk("drop", 8'hBC, 1'b0, 2'd3);
        valid_in = 4'hF;
        #1 chk("pre_pause_rdy", 32'(ready_out), 32'b0001);
        tick;
        out_chk("pre_pause", 8'hFF, 1'b1, 2'd0);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("pause_rdy", 32'(ready_out), 0);
            tick;
            out_chk("pause", 8'hBC, 1'b0, 2'd0);
        end
        pause = 1'b0;
        #1 chk("resume_rdy", 32'(ready_out), 32'b0010);
        tick;
        out_chk("resume", 8'hEE, 1'b1, 2'd1);
        reset_L = 1'b0;
        tick;
        out_chk("midrst", 8'hBC, 1'b0, 2'd0);
        chk("midrst_done", 32'(train_done), 0);
        chk("midrst_rdy", 32'(ready_out), 0);
        reset_L = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick;
            out_chk("retrain", 8'hBC, 1'b0, 2'd0);
            chk("retrain_done", 32'(train_done), (i == 4) ? 1 : 0);
        end
        chk("retrain_rdy", 32'(ready_out), 32'b0001);
        tick;
        out_chk("retrain_first", 8'hFF, 1'b1, 2'd0);
        for (int c = 0; c < 40; c++) begin
            r = 4'($urandom);
            valid_in = r | 4'b0100;
            #1;
            chk("fair_onehot", 32'($countones(ready_out)), 1);
            chk("fair_subset", 32'(ready_out & ~valid_in), 0);
            g2 = ready_out[2];
            tick;
            if (g2) begin
                out_chk("fair_l2", 8'h7F, 1'b1, 2'd2);
                grants2++;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
            chk("fair_wait", 32'(wait_cnt < 4), 1);
        end
        chk("fair_grants", 32'(grants2 >= 10), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
